// File: rtl/apb_conf_bridge_pkg.sv
// Shared widths, request type and issue-FSM encoding for the APB-to-confBus bridge.
`ifndef W_APB_ADDR
`define W_APB_ADDR 16
`endif
`ifndef W_APB_DATA
`define W_APB_DATA 32
`endif
`ifndef W_CONF_OFFS
`define W_CONF_OFFS 8
`endif
`ifndef W_CONF_DATA
`define W_CONF_DATA 32
`endif
`ifndef NUM_ANA_IPS
`define NUM_ANA_IPS 8
`endif
`ifndef NUM_ANA_CHS
`define NUM_ANA_CHS 8
`endif

package conf_bridge_pkg;
    localparam int APB_AW  = `W_APB_ADDR;
    localparam int APB_DW  = `W_APB_DATA;
    localparam int SEL_LSB = `W_CONF_OFFS + 2;
    localparam int SEL_W   = APB_AW - SEL_LSB;

    localparam logic [5:0] BCAST_SEL = 6'h3F;
    localparam logic [5:0] STAT_SEL  = 6'h3E;

    // Channel selectors live in a window starting at 32, after the IP selectors.
    localparam logic [6:0] IPS_END = 7'(`NUM_ANA_IPS);
    localparam logic [6:0] CH_BASE = 7'd32;
    localparam logic [6:0] CH_END  = 7'(32 + `NUM_ANA_CHS);

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] data;
        logic              bcast;
    } conf_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } issue_state_t;

    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel,
                                          input logic [SEL_W-1:0] bcast_sel);
        logic [6:0] s;
        s = 7'(sel);
        return (s < IPS_END) || ((s >= CH_BASE) && (s < CH_END)) || (sel == bcast_sel);
    endfunction
endpackage

// File: rtl/apb_conf_bridge_if.sv
// APB slave port plus confBus request port of the bridge, bundled in one interface.
interface apb_conf_bridge_if;
    import conf_bridge_pkg::*;

    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    logic [APB_AW-1:0] conf_address_o;
    logic [APB_DW-1:0] conf_data_o;
    logic              conf_write_o;
    logic              conf_broadcast_o;
    logic              conf_data_valid_o;
    logic              conf_block_ready_i;

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, conf_block_ready_i,
        output PRDATA, PREADY, PSLVERR,
        output conf_address_o, conf_data_o, conf_write_o, conf_broadcast_o, conf_data_valid_o
    );

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE, conf_block_ready_i,
        input  PRDATA, PREADY, PSLVERR,
        input  conf_address_o, conf_data_o, conf_write_o, conf_broadcast_o, conf_data_valid_o
    );
endinterface

// File: rtl/conf_req_fifo.sv
// Synchronous request FIFO; head_o shows the oldest entry whenever empty_o is low.
module conf_req_fifo
    import conf_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  conf_req_t                data_i,
    output conf_req_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW    = $clog2(DEPTH);
    localparam int LVL_W = PW + 1;

    conf_req_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [LVL_W-1:0] level_q;

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == LVL_W'(0));
    assign level_o = level_q;
endmodule

// File: rtl/apb_conf_bridge.sv
// APB slave that queues legal writes and replays them over the confBus request
// handshake, leaving GAP_CYC idle cycles after each accept for the master's sequence.
module apb_conf_bridge #(
    parameter int                                DEPTH     = 4,
    parameter int                                GAP_CYC   = 3,
    parameter logic [conf_bridge_pkg::SEL_W-1:0] BCAST_SEL = conf_bridge_pkg::BCAST_SEL,
    parameter logic [conf_bridge_pkg::SEL_W-1:0] STAT_SEL  = conf_bridge_pkg::STAT_SEL
) (
    input logic               clk,
    input logic               rst_n,
    apb_conf_bridge_if.slave  bus
);
    import conf_bridge_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(GAP_CYC + 1);

    logic [SEL_W-1:0]  sel_s;
    logic              access_s;
    logic              legal_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic              avail_s;
    logic              busy_s;
    logic [LVL_W-1:0]  level_s;
    logic [APB_DW-1:0] status_s;
    conf_req_t         in_req_s;
    conf_req_t         head_s;
    conf_req_t         next_req_s;
    conf_req_t         req_q;
    conf_req_t         req_d;
    issue_state_t      state_q;
    issue_state_t      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              valid_q;
    logic              valid_d;

    assign sel_s    = bus.PADDR[APB_AW-1:SEL_LSB];
    assign access_s = bus.PSEL & bus.PENABLE;
    assign legal_s  = sel_is_legal(sel_s, BCAST_SEL);
    assign push_s   = access_s & bus.PWRITE & legal_s & ~full_s;
    assign pop_s    = valid_q & bus.conf_block_ready_i;
    assign in_req_s = '{addr: bus.PADDR, data: bus.PWDATA, bcast: (sel_s == BCAST_SEL)};
    // A push into an empty FIFO is forwarded straight to the output registers.
    assign avail_s    = ~empty_s | push_s;
    assign next_req_s = empty_s ? in_req_s : head_s;
    assign busy_s     = ~empty_s | valid_q | (state_q == GAP);

    conf_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (in_req_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Status register image.
    always_comb begin
        status_s       = '0;
        status_s[15:8] = 8'(level_s);
        status_s[1]    = full_s;
        status_s[0]    = busy_s;
    end

    // APB response; PREADY only ever looks at the registered FIFO level.
    always_comb begin
        bus.PRDATA  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        if (access_s) begin
            if (bus.PWRITE && legal_s) begin
                bus.PREADY = ~full_s;
            end else if (!bus.PWRITE && (sel_s == STAT_SEL)) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = status_s;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = 1'b1;
            end
        end else begin
            bus.PREADY = 1'b0;
        end
    end

    // Issue FSM next state and next output register values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (avail_s) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                    req_d   = next_req_s;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (pop_s) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC);
                    valid_d = 1'b0;
                end else begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (avail_s) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                        req_d   = next_req_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue FSM state, gap counter and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign bus.conf_address_o    = req_q.addr;
    assign bus.conf_data_o       = req_q.data;
    assign bus.conf_broadcast_o  = req_q.bcast;
    assign bus.conf_write_o      = valid_q;
    assign bus.conf_data_valid_o = valid_q;
endmodule

// File: tb/tb_apb_conf_bridge.sv
// Self-checking bench for apb_conf_bridge: directed vectors, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_apb_conf_bridge;
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic        bcast;
    } req_t;

    typedef struct {
        logic        wr;
        logic [5:0]  sel;
        logic [31:0] d;
        logic        exp_err;
    } vec_t;

    logic   clk;
    logic   rst_n;
    int     n_checks = 0;
    int     n_fail   = 0;
    req_t   q[$];
    int     ready_mode = 0;
    logic   have_xfer  = 1'b0;
    time    last_xfer_t = 0;
    logic   prev_valid = 1'b0;
    req_t   prev_req;
    req_t   cur;
    logic   xfer;
    vec_t   vecs [11];

    apb_conf_bridge_if bus();

    apb_conf_bridge #(
        .DEPTH     (4),
        .GAP_CYC   (3),
        .BCAST_SEL (6'h3F),
        .STAT_SEL  (6'h3E)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Legal selectors with 8 IPs and 8 channels: 0..7, 32..39 and broadcast 63.
    function automatic logic ref_legal(input int sel);
        return (sel < 8) || ((sel >= 32) && (sel < 40)) || (sel == 63);
    endfunction

    // Master-side ready: 0 = hold off, 1 = always accept, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.conf_block_ready_i = 1'b0;
            1:       bus.conf_block_ready_i = 1'b1;
            default: bus.conf_block_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Request monitor: order, field stability, write flag and issue spacing.
    always begin
        @(negedge clk);
        xfer = 1'b0;
        if (rst_n) begin
            if (bus.conf_data_valid_o) begin
                cur = {bus.conf_address_o, bus.conf_data_o, bus.conf_broadcast_o};
                if (!prev_valid) begin
                    if (have_xfer) chk("issue_gap", 1'(($time - last_xfer_t) >= 35), 1'b1);
                    if (q.size() == 0) chk("spurious_valid", bus.conf_data_valid_o, 1'b0);
                    else               chk("req_fields", cur, q[0]);
                    chk("conf_write", bus.conf_write_o, 1'b1);
                end else begin
                    chk("req_hold", cur, prev_req);
                end
                prev_req = cur;
                xfer     = bus.conf_block_ready_i;
            end
            prev_valid = bus.conf_data_valid_o & ~xfer;
        end else begin
            prev_valid = 1'b0;
        end
        @(posedge clk);
        if (xfer && rst_n) begin
            if (q.size() > 0) void'(q.pop_front());
            last_xfer_t = $time;
            have_xfer   = 1'b1;
        end
    end

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_write(input logic [5:0] sel, input logic [9:0] low, input logic [31:0] d,
                             input logic exp_err, output int waits);
        logic done;
        bus.PADDR   = {sel, low};
        bus.PWDATA  = d;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.PREADY) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    chk("pready_timeout", bus.PREADY, 1'b1);
                    done = 1'b1;
                end
            end
        end
        chk("wr_pslverr", bus.PSLVERR, exp_err);
        @(posedge clk);
        if (!exp_err && bus.PREADY) q.push_back({sel, low, d, (sel == 6'h3F)});
        #1;
        bus_idle();
    endtask

    task automatic apb_read(input logic [5:0] sel, input string name);
        logic [31:0] exp_d;
        logic        exp_e;
        logic        busy;
        int          lvl;
        bus.PADDR   = {sel, 10'h000};
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        if (sel == 6'h3E) begin
            lvl   = q.size();
            busy  = (lvl != 0) || (have_xfer && (($time - last_xfer_t) < 30));
            exp_d = {16'h0000, 8'(lvl), 6'h00, 1'(lvl == 4), busy};
            exp_e = 1'b0;
        end else begin
            exp_d = 32'h0000_0000;
            exp_e = 1'b1;
        end
        chk({name, "_pready"}, bus.PREADY, 1'b1);
        chk({name, "_prdata"}, bus.PRDATA, exp_d);
        chk({name, "_pslverr"}, bus.PSLVERR, exp_e);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || (have_xfer && (($time - last_xfer_t) < 40))) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, 1'(n < 500), 1'b1);
    endtask

    initial begin
        int   w;
        logic [5:0] s;
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [5:0] s;

        vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, 1'b0};
        vecs[1]  = '{1'b1, 6'h07, 32'h0000_0002, 1'b0};
        vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, 1'b1};
        vecs[3]  = '{1'b1, 6'h1F, 32'h0000_0004, 1'b1};
        vecs[4]  = '{1'b1, 6'h20, 32'h0000_0005, 1'b0};
        vecs[5]  = '{1'b1, 6'h27, 32'h0000_0006, 1'b0};
        vecs[6]  = '{1'b1, 6'h28, 32'h0000_0007, 1'b1};
        vecs[7]  = '{1'b1, 6'h3E, 32'h0000_0008, 1'b1};
        vecs[8]  = '{1'b1, 6'h3F, 32'h0000_0009, 1'b0};
        vecs[9]  = '{1'b0, 6'h05, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 6'h3F, 32'h0000_0000, 1'b1};

        rst_n       = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus_idle();
        bus.conf_block_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  bus.conf_data_valid_o, 1'b0);
        chk("rst_write",  bus.conf_write_o, 1'b0);
        chk("rst_bcast",  bus.conf_broadcast_o, 1'b0);
        chk("rst_addr",   bus.conf_address_o, 16'h0000);
        chk("rst_data",   bus.conf_data_o, 32'h0);
        chk("rst_pready", bus.PREADY, 1'b0);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_pslverr", bus.PSLVERR, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_read(6'h3E, "rst_status");

        // Single write: valid one cycle after the push, fields as written
        ready_mode = 0;
        apb_write(6'd2, 10'h014, 32'h0000_00A5, 1'b0, w);
        @(negedge clk);
        chk("t1_valid", bus.conf_data_valid_o, 1'b1);
        chk("t1_addr",  bus.conf_address_o, 16'h0814);
        chk("t1_data",  bus.conf_data_o, 32'h0000_00A5);
        chk("t1_bcast", bus.conf_broadcast_o, 1'b0);
        @(posedge clk); #1;
        ready_mode = 1;
        wait_idle("t1");

        // Broadcast
        ready_mode = 0;
        apb_write(6'h3F, 10'h000, 32'h0000_0011, 1'b0, w);
        @(negedge clk);
        chk("t2_valid", bus.conf_data_valid_o, 1'b1);
        chk("t2_bcast", bus.conf_broadcast_o, 1'b1);
        @(posedge clk); #1;
        ready_mode = 1;
        wait_idle("t2");

        // Decode table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].sel, 10'h3FC, vecs[i].d, vecs[i].exp_err, w);
            else            apb_read(vecs[i].sel, "tbl_rd");
        end
        wait_idle("tbl");

        // Five writes into a 4-deep FIFO: the fifth stalls until the first pop
        ready_mode = 0;
        for (int i = 0; i < 4; i++) apb_write(6'(i + 1), 10'(i), 32'h5000_0000 + 32'(i), 1'b0, w);
        apb_read(6'h3E, "t3_full_status");
        fork
            apb_write(6'd5, 10'h005, 32'h5000_0004, 1'b0, w);
            begin
                repeat (6) @(posedge clk);
                #1;
                ready_mode = 1;
            end
        join
        chk("t3_wait_states", 1'(w > 0), 1'b1);
        wait_idle("t3");

        // Illegal write, then idle status
        apb_write(6'h1F, 10'h000, 32'hDEAD_BEEF, 1'b1, w);
        chk("t4_no_wait", w, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_no_valid", bus.conf_data_valid_o, 1'b0);
        @(posedge clk); #1;
        apb_read(6'h3E, "t4_status");

        // Status while requests are queued and after drain
        ready_mode = 0;
        for (int i = 0; i < 3; i++) apb_write(6'h20 + 6'(i), 10'h010, 32'h7000_0000 + 32'(i), 1'b0, w);
        apb_read(6'h3E, "t5_busy_status");
        ready_mode = 1;
        wait_idle("t5");
        apb_read(6'h3E, "t5_idle_status");

        // Reset while presenting with more requests queued
        ready_mode = 0;
        for (int i = 0; i < 3; i++) apb_write(6'(i), 10'h020, 32'h6000_0000 + 32'(i), 1'b0, w);
        @(negedge clk);
        chk("t6_valid_before", bus.conf_data_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", bus.conf_data_valid_o, 1'b0);
        q.delete();
        have_xfer = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ready_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        apb_read(6'h3E, "t6_status");

        // Randomized traffic against the reference queue
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       s = 6'($urandom_range(0, 7));
                1:       s = 6'($urandom_range(32, 39));
                2:       s = 6'h3F;
                default: s = 6'($urandom_range(0, 63));
            endcase
            apb_write(s, 10'($urandom), $urandom, !ref_legal(int'(s)), w);
            if ((i % 8) == 7) apb_read(6'h3E, "rand_status");
        end
        ready_mode = 1;
        wait_idle("rand");
        apb_read(6'h3E, "final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
